// File: rtl/fifo_chk_pkg.sv
// rtl/fifo_chk_pkg.sv - shared error codes, defaults and types for the FIFO checker
package fifo_chk_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE  = 2'd0;
    localparam err_t ERR_DATA  = 2'd1;
    localparam err_t ERR_FULL  = 2'd2;
    localparam err_t ERR_EMPTY = 2'd3;

endpackage

// File: rtl/chk_model_fifo.sv
// rtl/chk_model_fifo.sv - reference FIFO model: storage, pointers, occupancy and flags
module chk_model_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic                     rd_acc_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_acc, rd_acc;

    // Acceptance uses registered occupancy only: a same-cycle read never frees room for a write.
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_acc    = wr_en_i && !full_o;
    assign rd_acc    = rd_en_i && !empty_o;
    assign rd_acc_o  = rd_acc;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fifo_checker.sv
// rtl/fifo_checker.sv - scoreboard comparing snooped FIFO DUT reads and flags against a model
module fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mon_wr_en,
    input  logic [DATA_W-1:0]        mon_wr_data,
    input  logic                     mon_rd_en,
    input  logic [DATA_W-1:0]        mon_rd_data,
    input  logic                     mon_full,
    input  logic                     mon_empty,
    output logic                     pass_pulse,
    output logic                     fail_pulse,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   model_count,
    output logic                     any_fail
);

    logic              m_rd_acc;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_full, m_empty;

    chk_model_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_model (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (mon_wr_en),
        .wr_data_i (mon_wr_data),
        .rd_en_i   (mon_rd_en),
        .rd_acc_o  (m_rd_acc),
        .rd_data_o (m_rd_data),
        .count_o   (model_count),
        .full_o    (m_full),
        .empty_o   (m_empty)
    );

    // Expected read data travels alongside the DUT's read latency.
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [DATA_W-1:0] pipe_exp_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= m_rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_exp_q[0] <= m_rd_data;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_exp_q[i] <= pipe_exp_q[i-1];
        end
    end

    logic tail_vld;
    logic data_err, full_err, empty_err;
    err_t err_d;
    logic pass_d, fail_d, any_fail_d;

    assign tail_vld  = pipe_vld_q[RD_LAT-1];
    assign data_err  = tail_vld && (mon_rd_data != pipe_exp_q[RD_LAT-1]);
    assign full_err  = (mon_full != m_full);
    assign empty_err = (mon_empty != m_empty);

    // Only the highest-priority cause is reported; any error swallows a matching pass.
    always_comb begin
        err_d = ERR_NONE;
        if (data_err) begin
            err_d = ERR_DATA;
        end else if (full_err) begin
            err_d = ERR_FULL;
        end else if (empty_err) begin
            err_d = ERR_EMPTY;
        end
    end

    assign fail_d     = (err_d != ERR_NONE);
    assign pass_d     = tail_vld && !fail_d;
    assign any_fail_d = any_fail | fail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            err_code   <= ERR_NONE;
            any_fail   <= 1'b0;
        end else begin
            pass_pulse <= pass_d;
            fail_pulse <= fail_d;
            err_code   <= err_d;
            any_fail   <= any_fail_d;
        end
    end

endmodule

// File: doc/fifo_checker.md
Name: fifo_checker

Overview:
Self-checking monitor that produces the pass_pulse/fail_pulse stream consumed by the verification summary logger. It snoops the FIFO DUT's write/read ports and status flags, keeps a reference model of FIFO contents, and compares each DUT read datum and every flag against the model. Each compared read yields exactly one pass or fail pulse; flag mismatches yield fail pulses. It sits in the FIFO testbench between the DUT and the logger.

Parameters:
DATA_W, 8, width of FIFO data words
DEPTH, 16, model FIFO capacity; power of two, at least 2
RD_LAT, 1, cycles from accepted DUT read to valid mon_rd_data; legal values 1 or 2

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
mon_wr_en  in  1  DUT write enable, as observed
mon_wr_data  in  DATA_W  DUT write data
mon_rd_en  in  1  DUT read enable, as observed
mon_rd_data  in  DATA_W  DUT read data, valid RD_LAT cycles after an accepted read
mon_full  in  1  DUT full flag
mon_empty  in  1  DUT empty flag
pass_pulse  out  1  one-cycle pulse per matching read datum
fail_pulse  out  1  one-cycle pulse per detected error
err_code  out  2  error cause, valid only while fail_pulse=1, otherwise 0
model_count  out  $clog2(DEPTH)+1  model occupancy, 0..DEPTH
any_fail  out  1  sticky: set by the first fail_pulse, cleared only by rst

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high. On reset, all outputs are 0, wr/rd pointers are 0, model_count is 0, and the compare pipeline valid bits are cleared. In-flight compares are discarded, so no pulse arises from reads issued before reset.
- Accept rules, using registered model state at the clock edge:
  - Write accepted iff mon_wr_en && model_count != DEPTH.
  - Read accepted iff mon_rd_en && model_count != 0.
  - Full rule: write is blocked when full even if a read occurs in the same cycle, matching the DUT.
  - Simultaneous accepted read and write: count unchanged, both pointers advance.
- Pointers: $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. model_count is updated by +1, -1 or 0.
- Rejected operations: write on full and read on empty are ignored by the model. They produce no pulse and no pointer change. The DUT's flag behaviour is checked separately.
- Compare pipeline: an accepted read loads {valid, expected=mem[rd_ptr]} into an RD_LAT-deep shift register. When the tail is valid, mon_rd_data is compared with expected in that cycle. Outputs are registered, so the pulse appears RD_LAT+1 cycles after the read edge.
- Flag check, every cycle with rst=0:
  - mon_full must equal (model_count==DEPTH).
  - mon_empty must equal (model_count==0).
  - Both are compared against the model's current registered state.
- Error codes: 0 none, 1 data mismatch, 2 full flag mismatch, 3 empty flag mismatch.
- Same-cycle priority: data > full > empty. At most one fail_pulse per cycle.
- Mutual exclusion: pass_pulse and fail_pulse are never both 1. Any error in a cycle suppresses that cycle's pass, even if the data matched.
- Persistent flag mismatch: fail_pulse is asserted every cycle the mismatch persists.

Decomposition:
- Package fifo_chk_pkg:
  - ERR_NONE/ERR_DATA/ERR_FULL/ERR_EMPTY localparams
  - default DATA_W and DEPTH
  - 2-bit err_t typedef
- Sub-module chk_model_fifo: memory, pointers, count, accept logic, and the full/empty model flags.
- The top level holds the compare pipeline, flag checks, pulse generation and the sticky flag.

Test Plan:
- Directed data match, RD_LAT=1: write 0xA5 then 0x3C; read twice with the DUT returning 0xA5 then 0x3C -> two pass_pulses, each 2 cycles after its read edge; fail_pulse stays 0; model_count 2 -> 0.
- Data mismatch: write 0x3C; read, DUT returns 0x3D -> one fail_pulse with err_code=1; pass_pulse=0; any_fail=1 and stays 1 until rst.
- Full flag check: 16 writes of 0x00..0x0F with mon_full held 0 -> model_count=16, then fail_pulse with err_code=2 every cycle; a 17th write is ignored and model_count stays 16.
- Empty boundary: assert mon_rd_en with model empty and mon_empty=1 -> no pulse, pointers unchanged, model_count=0.
- Simultaneous ops at full: model_count=16, assert wr_en and rd_en together -> read accepted, write blocked, model_count=15; the read compares against entry 0x00.
- Mid-operation reset: accepted read, then rst=1 on the following edge -> no pass/fail pulse from that read; all outputs 0; model_count=0.
